// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt request controller feeding the special-register stage.
// Collects NSRC hardware lines (source ids 1..NSRC) plus the software `int`
// request (id 0). It applies mask and edge/level mode, and presents the
// lowest-numbered pending source as a registered irq_out/irq_instr pair. The
// taken id is held in irq_src until software writes EOI to STAT.
//
// Ports:
//   clk        core clock, rising edge
//   rst        asynchronous active-low reset
//   irq_lines  peripheral requests, bit k = source id k+1
//   int_req    one-cycle software interrupt pulse (id 0)
//   irq_en     interrupt enable from the special-register stage
//   cfg_we     register write strobe
//   cfg_addr   0 MASK, 1 MODE, 2 PEND, 3 STAT
//   cfg_wdata  register write data
//   cfg_rdata  register read data, combinational on cfg_addr
//   irq_out    interrupt request (irq_in of the special-register stage)
//   irq_instr  high with irq_out when the presented id is 0
//   irq_src    in-service source id
//
// Build option: define IRQC_SYNC_EN to put a 2-flop synchroniser on every
// irq_lines bit. This adds 2 cycles to the hardware-line latency.
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_lines,
  input  logic            int_req,
  input  logic            irq_en,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [15:0]     cfg_wdata,
  output logic [15:0]     cfg_rdata,
  output logic            irq_out,
  output logic            irq_instr,
  output logic [3:0]      irq_src
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t          r_state, w_state_nxt;
  logic [NSRC-1:0] w_line, r_line_d, w_rise;
  logic [NSRC:1]   r_mask, r_mode;
  logic [NSRC:0]   r_pend, w_pend_nxt, w_eff;
  logic            r_irq_out, r_irq_instr, w_irq_out_nxt, w_irq_instr_nxt;
  logic [3:0]      r_pres_id, w_pres_nxt, r_src, w_src_nxt, w_low_id;
  logic            w_eff_any, w_take, w_eoi, w_pend_wr;
  logic            w_unused;

`ifdef IRQC_SYNC_EN
  logic [NSRC-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_lines;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
`else
  assign w_line = irq_lines;
`endif

  assign w_rise    = w_line & ~r_line_d;
  assign w_eff     = r_pend & {r_mask, 1'b1};
  assign w_eff_any = |w_eff;
  assign w_take    = (r_state == S_REQ) && r_irq_out && irq_en;
  assign w_eoi     = cfg_we && (cfg_addr == 2'd3) && (r_state == S_SERVICE);
  assign w_pend_wr = cfg_we && (cfg_addr == 2'd2);
  // Bits above NSRC and the read-only bit 0 of MASK/MODE are ignored.
  assign w_unused  = ^cfg_wdata;

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    w_low_id = '0;
    for (int unsigned i = 0; i <= NSRC; i++) begin
      if (w_eff[NSRC-i]) w_low_id = 4'(NSRC - i);
    end
  end

  // Clears are applied before sets, so a set in the same cycle wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_take && (r_pres_id == '0)) w_pend_nxt[0] = 1'b0;
    if (int_req)                     w_pend_nxt[0] = 1'b1;
    for (int unsigned i = 1; i <= NSRC; i++) begin
      if (r_mode[i]) begin
        w_pend_nxt[i] = w_line[i-1];
      end else begin
        if (w_pend_wr && cfg_wdata[i])        w_pend_nxt[i] = 1'b0;
        if (w_take && (r_pres_id == 4'(i)))   w_pend_nxt[i] = 1'b0;
        if (w_rise[i-1])                      w_pend_nxt[i] = 1'b1;
      end
    end
  end

  // irq_out, irq_instr and the presented id are computed together here and
  // registered together, so the consumer always sees a consistent pair.
  always_comb begin
    w_state_nxt     = r_state;
    w_irq_out_nxt   = 1'b0;
    w_irq_instr_nxt = 1'b0;
    w_pres_nxt      = r_pres_id;
    w_src_nxt       = r_src;
    case (r_state)
      S_IDLE: begin
        if (w_eff_any) begin
          w_state_nxt     = S_REQ;
          w_irq_out_nxt   = 1'b1;
          w_pres_nxt      = w_low_id;
          w_irq_instr_nxt = (w_low_id == '0);
        end
      end
      S_REQ: begin
        if (w_take) begin
          w_state_nxt = S_SERVICE;
          w_src_nxt   = r_pres_id;
        end else if (!w_eff_any) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_irq_out_nxt   = 1'b1;
          w_pres_nxt      = w_low_id;
          w_irq_instr_nxt = (w_low_id == '0);
        end
      end
      S_SERVICE: begin
        if (w_eoi) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_irq_out   <= 1'b0;
      r_irq_instr <= 1'b0;
      r_pres_id   <= '0;
      r_src       <= '0;
      r_pend      <= '0;
      r_line_d    <= '0;
      r_mask      <= '0;
      r_mode      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_irq_out   <= w_irq_out_nxt;
      r_irq_instr <= w_irq_instr_nxt;
      r_pres_id   <= w_pres_nxt;
      r_src       <= w_src_nxt;
      r_pend      <= w_pend_nxt;
      r_line_d    <= w_line;
      if (cfg_we && (cfg_addr == 2'd0)) r_mask <= cfg_wdata[NSRC:1];
      if (cfg_we && (cfg_addr == 2'd1)) r_mode <= cfg_wdata[NSRC:1];
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata[NSRC:0] = {r_mask, 1'b1};
      2'd1:    cfg_rdata[NSRC:0] = {r_mode, 1'b0};
      2'd2:    cfg_rdata[NSRC:0] = r_pend;
      default: cfg_rdata[4:0]    = {(r_state == S_SERVICE), r_src};
    endcase
  end

  assign irq_out   = r_irq_out;
  assign irq_instr = r_irq_instr;
  assign irq_src   = r_src;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (NSRC = 8). Hardware-line latency depends on
// whether IRQC_SYNC_EN is defined; LAT carries that offset.
module tb_irq_ctrl;
  localparam int NSRC = 8;
`ifdef IRQC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] irq_lines;
  logic            int_req;
  logic            irq_en;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [15:0]     cfg_wdata;
  logic [15:0]     cfg_rdata;
  logic            irq_out;
  logic            irq_instr;
  logic [3:0]      irq_src;

  int n_vec = 0;
  int n_err = 0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_lines (irq_lines),
    .int_req   (int_req),
    .irq_en    (irq_en),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_out   (irq_out),
    .irq_instr (irq_instr),
    .irq_src   (irq_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] addr, input logic [15:0] exp, input string tag);
    cfg_addr = addr;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_lines = '0; int_req = 1'b0; irq_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    #3 rst = 1'b0;
    tick();
    chk("rst_irq_out", 16'(irq_out), 16'h0);
    chk("rst_irq_instr", 16'(irq_instr), 16'h0);
    chk("rst_irq_src", 16'(irq_src), 16'h0);
    rd(2'd0, 16'h0001, "rst_mask");
    rd(2'd1, 16'h0000, "rst_mode");
    rd(2'd2, 16'h0000, "rst_pend");
    tick();
    rd(2'd3, 16'h0000, "rst_stat");
    tick();
    rst = 1'b1;
    tick();

    // register widths: bits above NSRC read 0, MASK bit0 is 1, MODE bit0 is 0
    wr(2'd0, 16'hFFFF); rd(2'd0, 16'h01FF, "mask_width");
    wr(2'd1, 16'hFFFF); rd(2'd1, 16'h01FE, "mode_width");

    // single edge source id 2
    wr(2'd0, 16'h0004);
    wr(2'd1, 16'h0000);
    irq_en = 1'b1;
    irq_lines = 8'h02; tick(); irq_lines = '0;
    repeat (LAT) tick();
    rd(2'd2, 16'h0004, "t1_pend");
    chk("t1_out_lo", 16'(irq_out), 16'h0);
    tick();
    chk("t1_out_hi", 16'(irq_out), 16'h1);
    chk("t1_instr", 16'(irq_instr), 16'h0);
    tick();
    chk("t1_out_taken", 16'(irq_out), 16'h0);
    chk("t1_src", 16'(irq_src), 16'h2);
    rd(2'd3, 16'h0012, "t1_stat");
    rd(2'd2, 16'h0000, "t1_pend_clr");
    wr(2'd3, 16'h0000);
    rd(2'd3, 16'h0002, "t1_eoi");
    wr(2'd3, 16'h0000);
    rd(2'd3, 16'h0002, "t1_eoi_idle");

    // ids 2 and 4 together: priority then follow-up after EOI
    wr(2'd0, 16'h0014);
    irq_lines = 8'h0A; tick(); irq_lines = '0;
    repeat (LAT) tick();
    rd(2'd2, 16'h0014, "t2_pend");
    tick();
    chk("t2_out_hi", 16'(irq_out), 16'h1);
    tick();
    chk("t2_out_taken", 16'(irq_out), 16'h0);
    chk("t2_src_first", 16'(irq_src), 16'h2);
    rd(2'd2, 16'h0010, "t2_pend_left");
    wr(2'd3, 16'h0000);
    chk("t2_out_eoi", 16'(irq_out), 16'h0);
    rd(2'd3, 16'h0002, "t2_stat_idle");
    tick();
    chk("t2_out_next", 16'(irq_out), 16'h1);
    tick();
    chk("t2_src_second", 16'(irq_src), 16'h4);
    rd(2'd3, 16'h0014, "t2_stat");
    rd(2'd2, 16'h0000, "t2_pend_clr");
    wr(2'd3, 16'h0000);

    // software interrupt beats a masked hardware pending bit
    irq_en = 1'b0;
    wr(2'd0, 16'h0000);
    rd(2'd0, 16'h0001, "t3_mask");
    irq_lines = 8'h10; tick(); irq_lines = '0;
    repeat (LAT) tick();
    rd(2'd2, 16'h0020, "t3_pend5");
    tick();
    chk("t3_masked", 16'(irq_out), 16'h0);
    int_req = 1'b1; tick(); int_req = 1'b0;
    rd(2'd2, 16'h0021, "t3_pend_sw");
    chk("t3_out_lo", 16'(irq_out), 16'h0);
    tick();
    chk("t3_out_hi", 16'(irq_out), 16'h1);
    chk("t3_instr_hi", 16'(irq_instr), 16'h1);
    irq_en = 1'b1;
    tick();
    chk("t3_out_taken", 16'(irq_out), 16'h0);
    chk("t3_instr_lo", 16'(irq_instr), 16'h0);
    chk("t3_src", 16'(irq_src), 16'h0);
    rd(2'd3, 16'h0010, "t3_stat");
    rd(2'd2, 16'h0020, "t3_pend_after");
    wr(2'd3, 16'h0000);
    wr(2'd2, 16'h0020);
    rd(2'd2, 16'h0000, "t3_pend_wclr");

    // level mode id 1: re-request after EOI, drop while in REQ
    wr(2'd0, 16'h0002);
    wr(2'd1, 16'h0002);
    rd(2'd1, 16'h0002, "t4_mode");
    irq_lines = 8'h01; tick();
    repeat (LAT) tick();
    rd(2'd2, 16'h0002, "t4_pend");
    tick();
    chk("t4_out_hi", 16'(irq_out), 16'h1);
    tick();
    chk("t4_out_taken", 16'(irq_out), 16'h0);
    chk("t4_src", 16'(irq_src), 16'h1);
    rd(2'd2, 16'h0002, "t4_level_kept");
    rd(2'd3, 16'h0011, "t4_stat");
    wr(2'd3, 16'h0000);
    irq_en = 1'b0;
    chk("t4_out_eoi", 16'(irq_out), 16'h0);
    tick();
    chk("t4_rereq", 16'(irq_out), 16'h1);
    irq_lines = '0; tick();
    repeat (LAT) tick();
    rd(2'd2, 16'h0000, "t4_pend_drop");
    chk("t4_out_still", 16'(irq_out), 16'h1);
    tick();
    chk("t4_out_idle", 16'(irq_out), 16'h0);
    rd(2'd3, 16'h0001, "t4_stat_idle");

    // irq_en low holds the request; PEND write loses against a new edge
    wr(2'd1, 16'h0000);
    irq_lines = 8'h01; tick();
    repeat (LAT) tick();
    rd(2'd2, 16'h0002, "t5_pend");
    tick();
    chk("t5_out_hi", 16'(irq_out), 16'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_hold", 16'(irq_out), 16'h1);
    end
    rd(2'd3, 16'h0001, "t5_no_take");
    irq_lines = '0; tick();
    irq_lines = 8'h01;
    repeat (LAT) tick();
    wr(2'd2, 16'h0002);
    rd(2'd2, 16'h0002, "t5_set_wins");
    wr(2'd2, 16'h0002);
    rd(2'd2, 16'h0000, "t5_wclr");
    chk("t5_out_req", 16'(irq_out), 16'h1);
    tick();
    chk("t5_out_idle", 16'(irq_out), 16'h0);

    // asynchronous reset while in SERVICE
    irq_lines = '0;
    repeat (3) tick();
    irq_en = 1'b1;
    irq_lines = 8'h01; tick(); irq_lines = '0;
    repeat (LAT) tick();
    tick();
    chk("t6_out_hi", 16'(irq_out), 16'h1);
    tick();
    rd(2'd3, 16'h0011, "t6_service");
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_out", 16'(irq_out), 16'h0);
    chk("t6_rst_instr", 16'(irq_instr), 16'h0);
    chk("t6_rst_src", 16'(irq_src), 16'h0);
    rd(2'd0, 16'h0001, "t6_rst_mask");
    rd(2'd3, 16'h0000, "t6_rst_stat");
    rd(2'd2, 16'h0000, "t6_rst_pend");
    #4 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_req", 16'(irq_out), 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
